// File: rtl/clk_diff_out_if.sv
// Signal bundle for the forwarded differential clock generator.
// The master side drives divisor/handshake requests; the slave side is the generator.
interface clk_diff_out_if #(
    parameter int unsigned DIV_W = 8
);
    logic [DIV_W-1:0] div_half;
    logic             div_load;
    logic             start_req;
    logic             stop_req;
    logic             ack;
    logic             div_err;
    logic             running;
    logic             clkout_p;
    logic             clkout_n;
    logic             rise_stb;
    logic             fall_stb;

    modport master (
        output div_half, div_load, start_req, stop_req,
        input  ack, div_err, running, clkout_p, clkout_n, rise_stb, fall_stb
    );

    modport slave (
        input  div_half, div_load, start_req, stop_req,
        output ack, div_err, running, clkout_p, clkout_n, rise_stb, fall_stb
    );
endinterface

// File: rtl/clk_diff_out.sv
// Forwarded clock generator: programmable half-period, complementary output
// pair, glitch-free start/stop with ack, and registered edge strobes.
module clk_diff_out #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_HALF = 4
) (
    input  logic          clk,
    input  logic          rst,
    clk_diff_out_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             clk_q, clk_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             running_q, running_d;
    logic             wrap;

    // End of the current half-period
    assign wrap = (cnt_q == (half_q - DIV_W'(1)));

    // Next-state, counter, divisor and strobe decode
    always_comb begin
        state_d   = state_q;
        clk_d     = clk_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        // Divisor only changes while idle so a running clock never gets a short half
        if (bus.div_load) begin
            if (state_q == IDLE) begin
                half_d = (bus.div_half == '0) ? DIV_W'(1) : bus.div_half;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start_req) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    rise_d = ~clk_q;
                    fall_d = clk_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (bus.stop_req) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (!clk_q) begin
                        // Suppress the low->high edge: the clock parks low
                        state_d = IDLE;
                        ack_d   = 1'b1;
                    end else begin
                        clk_d  = 1'b0;
                        fall_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        running_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_q     <= 1'b0;
            cnt_q     <= '0;
            half_q    <= DIV_W'(DEFAULT_HALF);
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_q     <= clk_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            running_q <= running_d;
        end
    end

    assign bus.clkout_p = clk_q;
    assign bus.clkout_n = ~clk_q;
    assign bus.ack      = ack_q;
    assign bus.div_err  = err_q;
    assign bus.running  = running_q;
    assign bus.rise_stb = rise_q;
    assign bus.fall_stb = fall_q;
endmodule
